// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the I/D cache fill and write paths, and main memory.
// master = arbiter side, slave = caches plus memory side.
interface mem_arbiter_if #(
    parameter int IDXW = 3
);
    logic            icache_miss;
    logic [15:0]     icache_miss_addr;
    logic            dcache_miss;
    logic [15:0]     dcache_miss_addr;
    logic            dcache_wr_req;
    logic [15:0]     dcache_wr_addr;
    logic [15:0]     dcache_wr_data;
    logic            dcache_wr_ack;

    logic            mem_en;
    logic            mem_wr;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_wdata;
    logic [15:0]     mem_rdata;
    logic            mem_data_valid;

    logic            fill_we_i;
    logic            fill_we_d;
    logic [IDXW-1:0] fill_idx;
    logic [15:0]     fill_data;
    logic            fill_done_i;
    logic            fill_done_d;
    logic            busy;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        input  mem_rdata, mem_data_valid,
        output dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_we_i, fill_we_d, fill_idx, fill_data, fill_done_i, fill_done_d, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        output mem_rdata, mem_data_valid,
        input  dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_we_i, fill_we_d, fill_idx, fill_data, fill_done_i, fill_done_d, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between I-fill, D-fill and D write-through.
// Define MEM_ARB_RR_EN to arbitrate I/D misses round-robin instead of D-over-I.
//
// state   | meaning
// IDLE    | no access; grant evaluated and registered here
// WRITE   | single-cycle write-through to memory, ack pulsed
// FILL    | line fill for r_tgt_d (0=I, 1=D): issue reads, steer returned words
module mem_arbiter #(
    parameter int MEM_LATENCY    = 4,
    parameter int WORDS_PER_LINE = 8
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int              IDXW      = $clog2(WORDS_PER_LINE);
    localparam logic [15:0]     LINE_MASK = ~16'(2 * WORDS_PER_LINE - 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WORDS_PER_LINE - 1);

    generate
        if (MEM_LATENCY < 1 || WORDS_PER_LINE < 2 ||
            (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0) begin : g_bad_cfg
            $error("mem_arbiter: MEM_LATENCY must be >= 1 and WORDS_PER_LINE a power of 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_tgt_d;
    logic [15:0]     r_base;
    logic [IDXW-1:0] r_iss;
    logic            r_iss_done;
    logic [IDXW-1:0] r_rcv;

    logic            w_any_miss;
    logic            w_pick_d;

    logic            w_mem_en;
    logic            w_mem_wr;
    logic [15:0]     w_mem_addr;
    logic [15:0]     w_mem_wdata;
    logic            w_wr_ack;
    logic            w_we_i;
    logic            w_we_d;
    logic [IDXW-1:0] w_fill_idx;
    logic            w_done_i;
    logic            w_done_d;
    logic            w_busy;

`ifdef MEM_ARB_RR_EN
    logic            r_favor_d;

    always_comb begin
        w_any_miss = bus.dcache_miss | bus.icache_miss;
        w_pick_d   = bus.dcache_miss & (~bus.icache_miss | r_favor_d);
    end
`else
    always_comb begin
        w_any_miss = bus.dcache_miss | bus.icache_miss;
        w_pick_d   = bus.dcache_miss;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_mem_en    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_mem_wdata = 16'h0000;
        w_wr_ack    = 1'b0;
        w_we_i      = 1'b0;
        w_we_d      = 1'b0;
        w_fill_idx  = '0;
        w_done_i    = 1'b0;
        w_done_d    = 1'b0;
        w_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.dcache_wr_req) begin
                    w_state_nxt = S_WRITE;
                end else if (w_any_miss) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_WRITE: begin
                w_mem_en    = 1'b1;
                w_mem_wr    = 1'b1;
                w_mem_addr  = bus.dcache_wr_addr & 16'hFFFE;
                w_mem_wdata = bus.dcache_wr_data;
                w_wr_ack    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FILL: begin
                // Issue side runs ahead; receive side trails by the memory latency.
                w_mem_en   = ~r_iss_done;
                if (!r_iss_done) begin
                    w_mem_addr = r_base + (16'(r_iss) << 1);
                end
                w_fill_idx = r_rcv;
                w_we_i     = bus.mem_data_valid & ~r_tgt_d;
                w_we_d     = bus.mem_data_valid & r_tgt_d;
                if (bus.mem_data_valid && r_rcv == LAST_IDX) begin
                    w_done_i    = ~r_tgt_d;
                    w_done_d    = r_tgt_d;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tgt_d    <= 1'b0;
            r_base     <= 16'h0000;
            r_iss      <= '0;
            r_iss_done <= 1'b0;
            r_rcv      <= '0;
`ifdef MEM_ARB_RR_EN
            r_favor_d  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (!bus.dcache_wr_req && w_any_miss) begin
                        r_tgt_d    <= w_pick_d;
                        r_base     <= (w_pick_d ? bus.dcache_miss_addr : bus.icache_miss_addr) & LINE_MASK;
                        r_iss      <= '0;
                        r_iss_done <= 1'b0;
                        r_rcv      <= '0;
`ifdef MEM_ARB_RR_EN
                        // Pointer only moves when both sides actually contended.
                        if (bus.dcache_miss && bus.icache_miss) begin
                            r_favor_d <= ~w_pick_d;
                        end
`endif
                    end
                end
                S_FILL: begin
                    if (!r_iss_done) begin
                        if (r_iss == LAST_IDX) begin
                            r_iss_done <= 1'b1;
                        end else begin
                            r_iss <= r_iss + IDXW'(1);
                        end
                    end
                    if (bus.mem_data_valid) begin
                        r_rcv <= r_rcv + IDXW'(1);
                        if (r_rcv == LAST_IDX) begin
                            r_iss      <= '0;
                            r_iss_done <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_en        = w_mem_en;
    assign bus.mem_wr        = w_mem_wr;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_wdata     = w_mem_wdata;
    assign bus.dcache_wr_ack = w_wr_ack;
    assign bus.fill_we_i     = w_we_i;
    assign bus.fill_we_d     = w_we_d;
    assign bus.fill_idx      = w_fill_idx;
    assign bus.fill_data     = bus.mem_rdata;
    assign bus.fill_done_i   = w_done_i;
    assign bus.fill_done_d   = w_done_d;
    assign bus.busy          = w_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a timeline model of grants/fills checked every cycle,
// plus literal expectations for latencies and address sequences.
module tb_mem_arbiter;
    localparam int LAT  = 4;
    localparam int WPL  = 8;
    localparam int IDXW = 3;

    localparam int W_DONE_I = 0;
    localparam int W_DONE_D = 1;
    localparam int W_ACK    = 2;
    localparam int W_DONES  = 3;
    localparam int W_IDX_I  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.IDXW(IDXW)) bus ();

    mem_arbiter #(.MEM_LATENCY(LAT), .WORDS_PER_LINE(WPL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory return pipeline
    int          ret_cyc[$];
    logic [15:0] ret_addr[$];

    // model state: kind 0 none, 1 write, 2 fill; grant cycle and last busy cycle
    int          m_kind;
    int          m_g;
    int          m_end;
    logic [15:0] m_base;
    logic        m_tgt_d;
    logic        m_favor_d;

    // captures of DUT activity
    logic [15:0] rd_addrs[$];
    int          idx_i[$];
    int          we_i_cnt, we_d_cnt, ack_cnt, done_i_cnt, done_d_cnt;
    int          done_i_cyc, done_d_cyc, ack_cyc;
    logic [15:0] ack_addr, ack_wdata;

    logic [15:0] t1_exp [8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                                16'h1238, 16'h123A, 16'h123C, 16'h123E};
    logic [15:0] t6_exp [8] = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6,
                                16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE};

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_cycle();
        int t;
        int k;
        int j;
        logic        e_busy, e_en, e_wr, e_ack, e_wei, e_wed, e_di, e_dd;
        logic [15:0] e_addr, e_wdata;
        logic [IDXW-1:0] e_idx;
        logic [58:0] got_v, exp_v;
        logic        pick_d;
        t = cyc;
        e_busy = 0; e_en = 0; e_wr = 0; e_ack = 0; e_wei = 0; e_wed = 0; e_di = 0; e_dd = 0;
        e_addr = 16'h0; e_wdata = 16'h0; e_idx = '0;
        if (m_kind == 1 && t == m_g + 1) begin
            e_busy = 1; e_en = 1; e_wr = 1; e_ack = 1;
            e_addr = bus.dcache_wr_addr & 16'hFFFE;
            e_wdata = bus.dcache_wr_data;
        end
        if (m_kind == 2 && t > m_g && t <= m_g + WPL + LAT) begin
            e_busy = 1;
            k = t - m_g - 1;
            if (k < WPL) begin
                e_en = 1;
                e_addr = m_base + 16'(2 * k);
            end
            j = t - m_g - 1 - LAT;
            if (j >= 0) begin
                e_idx = IDXW'(j);
                if (m_tgt_d) e_wed = 1; else e_wei = 1;
                if (j == WPL - 1) begin
                    if (m_tgt_d) e_dd = 1; else e_di = 1;
                end
            end
        end
        exp_v = {e_busy, e_en, e_wr, e_addr, e_wdata, e_ack, e_wei, e_wed, e_idx, e_di, e_dd, bus.mem_rdata};
        got_v = {bus.busy, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.dcache_wr_ack,
                 bus.fill_we_i, bus.fill_we_d, bus.fill_idx, bus.fill_done_i, bus.fill_done_d, bus.fill_data};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%h expected=%h", t, got_v, exp_v);
        end

        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
            rd_addrs.push_back(bus.mem_addr);
            ret_cyc.push_back(t + LAT);
            ret_addr.push_back(bus.mem_addr);
        end
        if (bus.fill_we_i === 1'b1) begin idx_i.push_back(int'(bus.fill_idx)); we_i_cnt++; end
        if (bus.fill_we_d === 1'b1) we_d_cnt++;
        if (bus.fill_done_i === 1'b1) begin done_i_cnt++; done_i_cyc = t; end
        if (bus.fill_done_d === 1'b1) begin done_d_cnt++; done_d_cyc = t; end
        if (bus.dcache_wr_ack === 1'b1) begin
            ack_cnt++; ack_cyc = t; ack_addr = bus.mem_addr; ack_wdata = bus.mem_wdata;
        end

        if (rst) begin
            m_kind = 0; m_end = t; m_favor_d = 1'b1;
        end else if (t > m_end) begin
            if (bus.dcache_wr_req) begin
                m_kind = 1; m_g = t; m_end = t + 1;
            end else if (bus.dcache_miss || bus.icache_miss) begin
`ifdef MEM_ARB_RR_EN
                pick_d = bus.dcache_miss && (!bus.icache_miss || m_favor_d);
                if (bus.dcache_miss && bus.icache_miss) m_favor_d = !pick_d;
`else
                pick_d = bus.dcache_miss;
`endif
                m_kind = 2; m_g = t; m_end = t + WPL + LAT; m_tgt_d = pick_d;
                m_base = (pick_d ? bus.dcache_miss_addr : bus.icache_miss_addr) & ~16'(2 * WPL - 1);
            end
        end
    endtask

    initial begin
        m_kind = 0; m_g = -100; m_end = -1; m_favor_d = 1'b1; m_base = 16'h0; m_tgt_d = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_rdata = mem_word(ret_addr[0]);
                void'(ret_cyc.pop_front());
                void'(ret_addr.pop_front());
            end else begin
                bus.mem_data_valid = 1'b0;
                bus.mem_rdata = 16'(cyc * 309);
            end
            @(negedge clk);
            check_cycle();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_caps();
        rd_addrs.delete();
        idx_i.delete();
        we_i_cnt = 0; we_d_cnt = 0; ack_cnt = 0; done_i_cnt = 0; done_d_cnt = 0;
    endtask

    function automatic int count_of(input int which);
        case (which)
            W_DONE_I: return done_i_cnt;
            W_DONE_D: return done_d_cnt;
            W_ACK:    return ack_cnt;
            W_DONES:  return done_i_cnt + done_d_cnt;
            default:  return idx_i.size();
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int target, input int budget);
        int left;
        left = budget;
        while (count_of(which) < target && left > 0) begin
            @(negedge clk);
            #1;
            left--;
        end
        checks++;
        if (count_of(which) < target) begin
            errors++;
            $display("FAIL %s timeout count=%0d expected=%0d", name, count_of(which), target);
        end
    endtask

    task automatic miss_pair(input string name, input logic [15:0] exp_first);
        clear_caps();
        bus.dcache_miss = 1'b1; bus.dcache_miss_addr = 16'h0400;
        bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h0800;
        wait_for({name, "_first"}, W_DONES, 1, 40);
        step(1);
        if (done_d_cnt == 1) bus.dcache_miss = 1'b0;
        if (done_i_cnt == 1) bus.icache_miss = 1'b0;
        wait_for({name, "_second"}, W_DONES, 2, 40);
        step(1);
        bus.dcache_miss = 1'b0;
        bus.icache_miss = 1'b0;
        step(2);
        chk({name, "_nreads"}, rd_addrs.size(), 16);
        if (rd_addrs.size() == 16) begin
            chk({name, "_first_base"}, rd_addrs[0], exp_first);
            chk({name, "_second_base"}, rd_addrs[8], exp_first ^ 16'h0C00);
        end
        chk({name, "_gap"}, (done_i_cyc > done_d_cyc) ? done_i_cyc - done_d_cyc : done_d_cyc - done_i_cyc, 13);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        bus.icache_miss = 1'b0; bus.icache_miss_addr = 16'h0;
        bus.dcache_miss = 1'b0; bus.dcache_miss_addr = 16'h0;
        bus.dcache_wr_req = 1'b0; bus.dcache_wr_addr = 16'h0; bus.dcache_wr_data = 16'h0;
        done_i_cyc = 0; done_d_cyc = 0; ack_cyc = 0; ack_addr = 16'h0; ack_wdata = 16'h0;
        clear_caps();
        step(3);
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_fill_idx", bus.fill_idx, 0);
        step(1);

        // I fill from 0x1236
        clear_caps();
        bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h1236;
        r = cyc;
        wait_for("t1_done", W_DONE_I, 1, 40);
        chk("t1_done_latency", done_i_cyc - r, 12);
        step(1);
        bus.icache_miss = 1'b0;
        step(2);
        chk("t1_nreads", rd_addrs.size(), 8);
        for (int k = 0; k < 8 && k < rd_addrs.size(); k++) chk("t1_addr", rd_addrs[k], t1_exp[k]);
        for (int k = 0; k < 8 && k < idx_i.size(); k++) chk("t1_idx", idx_i[k], k);
        chk("t1_we_i", we_i_cnt, 8);
        chk("t1_we_d", we_d_cnt, 0);

        // write-through
        clear_caps();
        bus.dcache_wr_req = 1'b1; bus.dcache_wr_addr = 16'h0043; bus.dcache_wr_data = 16'hBEEF;
        r = cyc;
        wait_for("t2_ack", W_ACK, 1, 10);
        chk("t2_ack_latency", ack_cyc - r, 1);
        chk("t2_addr", ack_addr, 16'h0042);
        chk("t2_wdata", ack_wdata, 16'hBEEF);
        step(1);
        bus.dcache_wr_req = 1'b0;
        step(3);
        chk("t2_ack_count", ack_cnt, 1);
        chk("t2_no_reads", rd_addrs.size(), 0);

        // simultaneous misses
        miss_pair("t3a", 16'h0400);
`ifdef MEM_ARB_RR_EN
        miss_pair("t3b", 16'h0800);
`else
        miss_pair("t3b", 16'h0400);
`endif

        // write raised mid I fill
        clear_caps();
        bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h3000;
        wait_for("t4_word3", W_IDX_I, 4, 40);
        bus.dcache_wr_req = 1'b1; bus.dcache_wr_addr = 16'h3101; bus.dcache_wr_data = 16'h1234;
        wait_for("t4_done", W_DONE_I, 1, 40);
        step(1);
        bus.icache_miss = 1'b0;
        wait_for("t4_ack", W_ACK, 1, 10);
        chk("t4_ack_after_done", ack_cyc - done_i_cyc, 2);
        chk("t4_words", idx_i.size(), 8);
        chk("t4_ack_addr", ack_addr, 16'h3100);
        step(1);
        bus.dcache_wr_req = 1'b0;
        step(2);

        // reset mid D fill after 5 words
        clear_caps();
        bus.dcache_miss = 1'b1; bus.dcache_miss_addr = 16'h2468;
        r = cyc;
        while (cyc < r + 9) step(1);
        rst = 1'b1;
        bus.dcache_miss = 1'b0;
        step(1);
        rst = 1'b0;
        chk("t5_busy_after_rst", bus.busy, 0);
        chk("t5_mem_en_after_rst", bus.mem_en, 0);
        step(8);
        chk("t5_we_d", we_d_cnt, 5);
        chk("t5_no_done", done_d_cnt, 0);
        chk("t5_we_i", we_i_cnt, 0);

        // line at top of address space
        clear_caps();
        bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'hFFFE;
        wait_for("t6_done", W_DONE_I, 1, 40);
        step(1);
        bus.icache_miss = 1'b0;
        step(2);
        chk("t6_nreads", rd_addrs.size(), 8);
        for (int k = 0; k < 8 && k < rd_addrs.size(); k++) chk("t6_addr", rd_addrs[k], t6_exp[k]);
        if (idx_i.size() > 0) chk("t6_last_idx", idx_i[idx_i.size() - 1], 7);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
